fetch_queue: RTL and testbench

- Receiver end of the front-end fetch interface: accepts groups of `MACHINE_WIDTH FETCH_PACKETs from fetch, buffers them, and presents one group per cycle to decode.
- Drives per-lane fetch_pkt_ready back to fetch.
- Discards all buffered groups on a retire-time branch mispredict (retire_br_misp).
- Sits between fetch and decode in the core pipeline.

---
 rtl/fetch_queue_pkg.sv | 29 ++
 rtl/fq_ptr_ctrl.sv | 52 +++++
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: fetch packet, lane group and default depth.
// MACHINE_WIDTH and XLEN are global macros; defaults apply only when the build leaves them undefined.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

package fetch_queue_pkg;
  localparam int unsigned MW       = `MACHINE_WIDTH;
  localparam int unsigned FQ_DEPTH = 4;

  typedef struct packed {
    logic              valid;
    logic [`XLEN-1:0]  pc;
    logic [31:0]       inst;
  } FETCH_PACKET;

  typedef FETCH_PACKET [0:MW-1] FETCH_GROUP;

  // A group is worth storing only if at least one lane carries an instruction.
  function automatic logic any_valid(input FETCH_GROUP g);
    logic v;
    v = 1'b0;
    for (int i = 0; i < int'(MW); i++) v = v | g[i].valid;
    return v;
  endfunction
endpackage

// File: rtl/fq_ptr_ctrl.sv
// Read/write pointer bookkeeping for the fetch queue; pointers carry an extra wrap bit.
module fq_ptr_ctrl
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq,
  input  logic                       deq,
  input  logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   wr_idx_c,
  output logic [$clog2(DEPTH)-1:0]   rd_idx_nxt_c,
  output logic                       full_nxt_c,
  output logic                       empty_nxt_c,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;

  // Flush wins over any same-cycle enqueue or dequeue.
  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (enq) wr_nxt = wr_ptr + PW'(1);
      if (deq) rd_nxt = rd_ptr + PW'(1);
    end
  end

  assign wr_idx_c     = wr_ptr[AW-1:0];
  assign rd_idx_nxt_c = rd_nxt[AW-1:0];
  assign full_nxt_c   = (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
  assign empty_nxt_c  = (wr_nxt == rd_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      occupancy <= wr_nxt - rd_nxt;
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode group buffer with retire-time flush; all outputs come straight from flops.
// Optional FETCH_QUEUE_STALL_CNT_EN adds saturating stall_cnt / flush_cnt event counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  FETCH_GROUP              fetch_pkt,
  output logic [MW-1:0]           fetch_pkt_ready,
  input  logic                    retire_br_misp,
  output FETCH_GROUP              dec_pkt,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [$clog2(DEPTH):0]  occupancy
`ifdef FETCH_QUEUE_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          grp_valid_c, enq_c, deq_c;
  logic          full_nxt_c, empty_nxt_c;
  logic [AW-1:0] wr_idx_c, rd_idx_nxt_c;
  FETCH_GROUP    head_nxt_c;
  FETCH_GROUP    mem [DEPTH];

  assign grp_valid_c = any_valid(fetch_pkt);
  assign enq_c       = (&fetch_pkt_ready) && grp_valid_c && !retire_br_misp;
  assign deq_c       = dec_valid && dec_ready && !retire_br_misp;

  fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq          (enq_c),
    .deq          (deq_c),
    .flush        (retire_br_misp),
    .wr_idx_c     (wr_idx_c),
    .rd_idx_nxt_c (rd_idx_nxt_c),
    .full_nxt_c   (full_nxt_c),
    .empty_nxt_c  (empty_nxt_c),
    .occupancy    (occupancy)
  );

  always_ff @(posedge clk) begin
    if (enq_c) mem[wr_idx_c] <= fetch_pkt;
  end

  // Next head: an enqueue into an empty queue lands in the head slot and must bypass the array.
  always_comb begin
    head_nxt_c = '0;
    if (!empty_nxt_c) begin
      if (enq_c && (wr_idx_c == rd_idx_nxt_c)) head_nxt_c = fetch_pkt;
      else                                     head_nxt_c = mem[rd_idx_nxt_c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pkt_ready <= '1;
      dec_valid       <= 1'b0;
      dec_pkt         <= '0;
    end else begin
      fetch_pkt_ready <= {MW{!full_nxt_c}};
      dec_valid       <= !empty_nxt_c;
      dec_pkt         <= head_nxt_c;
    end
  end

`ifdef FETCH_QUEUE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (grp_valid_c && !(&fetch_pkt_ready) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (retire_br_misp && (flush_cnt != '1))                   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model compared every cycle plus directed literal checks.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GW    = $bits(FETCH_GROUP);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       misp = 1'b0;
  logic       dec_ready = 1'b0;
  FETCH_GROUP fp = '0;
  FETCH_GROUP dec_pkt;
  logic [MW-1:0] rdy;
  logic       dec_valid;
  logic [2:0] occ;
`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  FETCH_GROUP mq[$];
  logic [31:0] seen[$];
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pkt       (fp),
    .fetch_pkt_ready (rdy),
    .retire_br_misp  (misp),
    .dec_pkt         (dec_pkt),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .occupancy       (occ)
`ifdef FETCH_QUEUE_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic FETCH_GROUP mk(input logic [31:0] base, input logic [MW-1:0] vm);
    FETCH_GROUP g;
    for (int i = 0; i < int'(MW); i++) begin
      g[i].valid = vm[i];
      g[i].pc    = `XLEN'(base + 32'(4 * i));
      g[i].inst  = 32'hC0DE_0000 ^ 32'(base + 32'(4 * i));
    end
    return g;
  endfunction

  // Advance one clock: model decides from pre-edge state, then updates after the edge.
  task automatic cycle();
    bit anyv, m_enq, m_deq;
    anyv = 1'b0;
    for (int i = 0; i < int'(MW); i++) anyv = anyv | fp[i].valid;
    m_enq = (mq.size() < DEPTH) && anyv && !misp;
    m_deq = (mq.size() > 0) && dec_ready && !misp;
    if (anyv && mq.size() >= DEPTH) m_stall++;
    if (misp) m_flush++;
    if (dec_valid && dec_ready && !misp) seen.push_back(32'(dec_pkt[0].pc));
    @(posedge clk);
    if (misp) mq.delete();
    else begin
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back(fp);
    end
    #1;
  endtask

  always @(negedge clk) begin
    FETCH_GROUP exp_head;
    if (check_en) begin
      exp_head = '0;
      if (mq.size() > 0) exp_head = mq[0];
      chk("cyc_ready", GW'(rdy), GW'({MW{mq.size() < DEPTH}}));
      chk("cyc_dec_valid", GW'(dec_valid), GW'(mq.size() > 0));
      chk("cyc_occupancy", GW'(occ), GW'(mq.size()));
      chk("cyc_dec_pkt", GW'(dec_pkt), GW'(exp_head));
`ifdef FETCH_QUEUE_STALL_CNT_EN
      chk("cyc_stall_cnt", GW'(stall_cnt), GW'(m_stall));
      chk("cyc_flush_cnt", GW'(flush_cnt), GW'(m_flush));
`endif
    end
  end

  initial begin
    int k;
    bit acc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;
    chk("rst_ready", GW'(rdy), GW'(4'b1111));
    chk("rst_dec_valid", GW'(dec_valid), GW'(0));
    chk("rst_occupancy", GW'(occ), GW'(0));
    chk("rst_dec_pkt", GW'(dec_pkt), GW'(0));

    // Single group in and out
    fp = mk(32'h1000, 4'hF); dec_ready = 1'b0; cycle();
    fp = '0;
    chk("single_valid", GW'(dec_valid), GW'(1));
    chk("single_pc0", GW'(dec_pkt[0].pc), GW'(32'h1000));
    chk("single_pc3", GW'(dec_pkt[3].pc), GW'(32'h100C));
    chk("single_occ", GW'(occ), GW'(1));
    dec_ready = 1'b1; cycle();
    chk("single_deq_occ", GW'(occ), GW'(0));
    chk("single_deq_valid", GW'(dec_valid), GW'(0));

    // All-invalid group is dropped; partially valid group is kept whole
    fp = mk(32'h2000, 4'h0); dec_ready = 1'b0; cycle();
    chk("drop_occ", GW'(occ), GW'(0));
    fp = mk(32'h3000, 4'b0100); cycle();
    fp = '0;
    chk("partial_occ", GW'(occ), GW'(1));
    chk("partial_lane0_valid", GW'(dec_pkt[0].valid), GW'(0));
    chk("partial_lane0_pc", GW'(dec_pkt[0].pc), GW'(32'h3000));
    dec_ready = 1'b1; cycle();

    // Fill to full, then hold a fifth group
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fp = mk(32'h1000 + 32'(16 * i), 4'hF); cycle();
    end
    chk("full_occ", GW'(occ), GW'(4));
    chk("full_ready", GW'(rdy), GW'(4'b0000));
    fp = mk(32'h1040, 4'hF);
    repeat (3) cycle();
    chk("full_hold_occ", GW'(occ), GW'(4));
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("stall_cnt_3", GW'(stall_cnt), GW'(3));
`endif

    // Dequeue from full: ready comes back only after the edge
    fp = '0; dec_ready = 1'b1;
    chk("full_deq_same_cycle_ready", GW'(rdy), GW'(4'b0000));
    cycle();
    dec_ready = 1'b0;
    chk("full_deq_occ", GW'(occ), GW'(3));
    chk("full_deq_ready", GW'(rdy), GW'(4'b1111));
    dec_ready = 1'b1;
    repeat (3) cycle();
    chk("drain_occ", GW'(occ), GW'(0));

    // Wrap-around ordering with toggling decode
    seen.delete();
    k = 0;
    for (int c = 0; c < 100 && k < 10; c++) begin
      fp = mk(32'h1000 + 32'(16 * k), 4'hF);
      dec_ready = (c % 2 == 0);
      acc = (mq.size() < DEPTH);
      cycle();
      if (acc) k++;
    end
    chk("wrap_sent", GW'(k), GW'(10));
    fp = '0; dec_ready = 1'b1;
    for (int c = 0; c < 20 && mq.size() > 0; c++) cycle();
    chk("wrap_seen_count", GW'(seen.size()), GW'(10));
    for (int i = 0; i < 10 && i < seen.size(); i++)
      chk($sformatf("wrap_pc%0d", i), GW'(seen[i]), GW'(32'h1000 + 32'(16 * i)));

    // Flush beats simultaneous enqueue and dequeue
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fp = mk(32'h4000 + 32'(16 * i), 4'hF); cycle();
    end
    chk("pre_flush_occ", GW'(occ), GW'(3));
    fp = mk(32'h4030, 4'hF); dec_ready = 1'b1; misp = 1'b1; cycle();
    misp = 1'b0; dec_ready = 1'b0; fp = '0;
    chk("flush_occ", GW'(occ), GW'(0));
    chk("flush_valid", GW'(dec_valid), GW'(0));
    chk("flush_pkt", GW'(dec_pkt), GW'(0));
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("flush_cnt_1", GW'(flush_cnt), GW'(1));
`endif
    cycle();
    fp = mk(32'h5000, 4'hF); cycle();
    fp = '0;
    chk("post_flush_head", GW'(dec_pkt[0].pc), GW'(32'h5000));
    chk("post_flush_valid", GW'(dec_valid), GW'(1));

    // Flush while full
    for (int i = 0; i < 3; i++) begin
      fp = mk(32'h6000 + 32'(16 * i), 4'hF); cycle();
    end
    fp = '0;
    chk("full2_occ", GW'(occ), GW'(4));
    misp = 1'b1; cycle(); misp = 1'b0;
    chk("flush_full_occ", GW'(occ), GW'(0));
    chk("flush_full_ready", GW'(rdy), GW'(4'b1111));

    // Asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) begin
      fp = mk(32'h7000 + 32'(16 * i), 4'hF); cycle();
    end
    fp = '0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_occ", GW'(occ), GW'(0));
    chk("async_rst_valid", GW'(dec_valid), GW'(0));
    chk("async_rst_pkt", GW'(dec_pkt), GW'(0));
    chk("async_rst_ready", GW'(rdy), GW'(4'b1111));
    mq.delete(); m_stall = 0; m_flush = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    fp = mk(32'h8000, 4'hF); cycle();
    fp = '0;
    chk("post_rst_head", GW'(dec_pkt[0].pc), GW'(32'h8000));
    dec_ready = 1'b1; cycle(); cycle();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
